// File: rtl/csr_file.sv
// Machine-mode CSR file: RW/RS/RC accesses, custom scratch bank, 64-bit cycle/instret counters.
// Results (old value or illegal flag) are registered and returned one cycle after the access.
module csr_file #(
    parameter int          NUM_SCRATCH  = 4,
    parameter logic [11:0] SCRATCH_BASE = 12'h7C0,
    parameter int          CNT_W        = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_valid,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_src_zero,
    input  logic        instr_retire,
    output logic [31:0] csr_rdata,
    output logic        csr_rvalid,
    output logic        csr_illegal
);

    localparam int HI_W = CNT_W - 32;

    function automatic logic [31:0] rmw(input logic [1:0] op, input logic [31:0] old,
                                        input logic [31:0] src);
        case (op)
            2'b10:   rmw = old | src;
            2'b11:   rmw = old & ~src;
            default: rmw = src;
        endcase
    endfunction

    function automatic logic [31:0] hi_ext(input logic [HI_W-1:0] h);
        hi_ext = 32'(h);
    endfunction

    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] minstret;
    logic [31:0]      scratch [NUM_SCRATCH];

    logic        access, wr_try, cnt_hit, scr_hit, sel_hi, sel_ins, ro, illegal, do_wr;
    logic [11:0] scr_off;
    logic [31:0] scr_old, old_val, new_val;
    logic        wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;

    logic [31:0] rdata_p1;
    logic        vld_p1, ill_p1;

    // p0: decode and read-modify-write on the sampled request
    // Counter space: 0xBxx (machine, RW) and 0xCxx (user alias, RO); only bits 7 (half) and 1 (which) vary.
    always_comb begin
        access  = csr_valid && (csr_op != 2'b00);
        wr_try  = (csr_op == 2'b01) || !csr_src_zero;
        ro      = (csr_addr[11:10] == 2'b11);
        sel_hi  = csr_addr[7];
        sel_ins = csr_addr[1];
        cnt_hit = ((csr_addr[11:8] == 4'hB) || (csr_addr[11:8] == 4'hC))
                  && ((csr_addr[7:0] & 8'h7D) == 8'h00);
        scr_off = csr_addr - SCRATCH_BASE;
        scr_hit = !cnt_hit && (scr_off < 12'(NUM_SCRATCH));
        illegal = !(cnt_hit || scr_hit) || (wr_try && ro);
        do_wr   = access && !illegal && wr_try;
    end

    always_comb begin
        scr_old = 32'h0;
        for (int i = 0; i < NUM_SCRATCH; i++)
            if (scr_off == 12'(i)) scr_old = scratch[i];
    end

    always_comb begin
        case ({cnt_hit, sel_ins, sel_hi})
            3'b100:  old_val = mcycle[31:0];
            3'b101:  old_val = hi_ext(mcycle[CNT_W-1:32]);
            3'b110:  old_val = minstret[31:0];
            3'b111:  old_val = hi_ext(minstret[CNT_W-1:32]);
            default: old_val = scr_old;
        endcase
        new_val   = rmw(csr_op, old_val, csr_wdata);
        wr_cyc_lo = do_wr && cnt_hit && !sel_ins && !sel_hi;
        wr_cyc_hi = do_wr && cnt_hit && !sel_ins &&  sel_hi;
        wr_ins_lo = do_wr && cnt_hit &&  sel_ins && !sel_hi;
        wr_ins_hi = do_wr && cnt_hit &&  sel_ins &&  sel_hi;
    end

    // A half-write replaces that half only and swallows the same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_cyc_lo)      mcycle[31:0]       <= new_val;
            else if (wr_cyc_hi) mcycle[CNT_W-1:32] <= new_val[HI_W-1:0];
            else                mcycle             <= mcycle + CNT_W'(1);

            if (wr_ins_lo)         minstret[31:0]       <= new_val;
            else if (wr_ins_hi)    minstret[CNT_W-1:32] <= new_val[HI_W-1:0];
            else if (instr_retire) minstret             <= minstret + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= 32'h0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (do_wr && scr_hit && (scr_off == 12'(i))) scratch[i] <= new_val;
        end
    end

    // p1: registered response for the writeback mux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            ill_p1   <= 1'b0;
            rdata_p1 <= 32'h0;
        end else begin
            vld_p1   <= access;
            ill_p1   <= access && illegal;
            rdata_p1 <= (access && !illegal) ? old_val : 32'h0;
        end
    end

    assign csr_rdata   = rdata_p1;
    assign csr_rvalid  = vld_p1;
    assign csr_illegal = ill_p1;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus randomized accesses against an abstract CSR model.
module tb_csr_file;

    localparam int          NS   = 4;
    localparam logic [11:0] SB   = 12'h7C0;
    localparam int          CW   = 64;
    localparam logic [63:0] MASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_valid = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h0;
    logic [31:0] csr_wdata = 32'h0;
    logic        csr_src_zero = 1'b0;
    logic        instr_retire = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_illegal;

    csr_file #(.NUM_SCRATCH(NS), .SCRATCH_BASE(SB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero), .instr_retire(instr_retire),
        .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Abstract model state: counters as plain integers modulo 2^CW, scratch as an array.
    logic [63:0] m_cyc, m_ins;
    logic [31:0] m_scr [NS];
    logic        e_vld, e_ill;
    logic [31:0] e_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cyc = 64'h0;
        m_ins = 64'h0;
        for (int i = 0; i < NS; i++) m_scr[i] = 32'h0;
        e_vld = 1'b0; e_ill = 1'b0; e_rdata = 32'h0;
    endtask

    task automatic model_edge();
        logic        acc, wt, ill;
        int          kind, idx;
        logic [31:0] old, nv;
        logic [63:0] cyc_n, ins_n;
        acc  = csr_valid && (csr_op != 2'b00);
        kind = 0;
        idx  = int'(csr_addr) - int'(SB);
        case (csr_addr)
            12'hB00, 12'hC00: kind = 1;
            12'hB80, 12'hC80: kind = 2;
            12'hB02, 12'hC02: kind = 3;
            12'hB82, 12'hC82: kind = 4;
            default: if (idx >= 0 && idx < NS) kind = 5;
        endcase
        case (kind)
            1: old = m_cyc[31:0];
            2: old = m_cyc[63:32];
            3: old = m_ins[31:0];
            4: old = m_ins[63:32];
            5: old = m_scr[idx];
            default: old = 32'h0;
        endcase
        if (csr_op == 2'b01)      nv = csr_wdata;
        else if (csr_op == 2'b10) nv = old | csr_wdata;
        else                      nv = old & ~csr_wdata;
        wt  = (csr_op == 2'b01) || !csr_src_zero;
        ill = (kind == 0) || (wt && csr_addr >= 12'hC00);
        cyc_n = (m_cyc + 64'd1) & MASK;
        ins_n = instr_retire ? ((m_ins + 64'd1) & MASK) : m_ins;
        if (acc && !ill && wt) begin
            case (kind)
                1: cyc_n = {m_cyc[63:32], nv};
                2: cyc_n = {nv, m_cyc[31:0]} & MASK;
                3: ins_n = {m_ins[63:32], nv};
                4: ins_n = {nv, m_ins[31:0]} & MASK;
                5: m_scr[idx] = nv;
                default: ;
            endcase
        end
        m_cyc   = cyc_n;
        m_ins   = ins_n;
        e_vld   = acc;
        e_ill   = acc && ill;
        e_rdata = (acc && !ill) ? old : 32'h0;
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input logic sz, input logic ret, input string tag);
        csr_valid = v; csr_op = op; csr_addr = a; csr_wdata = wd;
        csr_src_zero = sz; instr_retire = ret;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check({tag, "_rvalid"}, csr_rvalid, e_vld);
        check({tag, "_illegal"}, csr_illegal, e_ill);
        if (e_vld) check({tag, "_rdata"}, csr_rdata, e_rdata);
    endtask

    task automatic idle(input int n, input logic ret);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 12'h000, 32'h0, 1'b0, ret, "idle");
    endtask

    task automatic rd(input logic [11:0] a, input string tag);
        step(1'b1, 2'b10, a, 32'h0, 1'b1, 1'b0, tag);
    endtask

    task automatic do_reset();
        csr_valid = 1'b0; csr_op = 2'b00; instr_retire = 1'b0;
        rst = 1'b1;
        #3;
        model_clear();
        check("reset_rvalid", csr_rvalid, 1'b0);
        check("reset_illegal", csr_illegal, 1'b0);
        check("reset_rdata", csr_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [11:0] addrs [16] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                12'hC02, 12'hC82, 12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3,
                                12'h7C4, 12'h7BF, 12'h300, 12'hB01};

    initial begin
        do_reset();

        idle(10, 1'b0);
        rd(12'hB00, "tp_cnt10");
        check("tp_cnt10_val", csr_rdata, 32'd10);
        check("tp_cnt10_legal", csr_illegal, 1'b0);
        idle(1, 1'b0);
        check("tp_rvalid_pulse", csr_rvalid, 1'b0);

        step(1'b1, 2'b01, 12'h7C1, 32'hDEADBEEF, 1'b0, 1'b0, "tp_rw");
        check("tp_rw_old", csr_rdata, 32'h0);
        step(1'b1, 2'b10, 12'h7C1, 32'h0000000F, 1'b0, 1'b0, "tp_rs");
        check("tp_rs_old", csr_rdata, 32'hDEADBEEF);
        step(1'b1, 2'b11, 12'h7C1, 32'hFFFF0000, 1'b0, 1'b0, "tp_rc");
        check("tp_rc_old", csr_rdata, 32'hDEADBEEF);
        rd(12'h7C1, "tp_scr_final");
        check("tp_scr_final_val", csr_rdata, 32'h0000BEEF);

        step(1'b1, 2'b01, 12'hC00, 32'h5, 1'b0, 1'b0, "tp_ro_wr");
        check("tp_ro_wr_ill", csr_illegal, 1'b1);
        check("tp_ro_wr_rdata", csr_rdata, 32'h0);
        rd(12'hC00, "tp_ro_rd");
        check("tp_ro_rd_legal", csr_illegal, 1'b0);
        step(1'b1, 2'b01, 12'h7C4, 32'h1, 1'b0, 1'b0, "tp_scr_oob");
        check("tp_scr_oob_ill", csr_illegal, 1'b1);

        step(1'b1, 2'b01, 12'hB00, 32'hFFFFFFFF, 1'b0, 1'b0, "tp_wr_lo");
        step(1'b1, 2'b01, 12'hB80, 32'hFFFFFFFF, 1'b0, 1'b0, "tp_wr_hi");
        rd(12'hC80, "tp_pre_wrap");
        check("tp_pre_wrap_val", csr_rdata, 32'hFFFFFFFF);
        rd(12'hC00, "tp_wrap");
        check("tp_wrap_val", csr_rdata, 32'h0);

        step(1'b1, 2'b01, 12'hB02, 32'h5, 1'b0, 1'b1, "tp_ins_wr");
        rd(12'hB02, "tp_ins5");
        check("tp_ins5_val", csr_rdata, 32'd5);
        idle(3, 1'b1);
        rd(12'hB02, "tp_ins8");
        check("tp_ins8_val", csr_rdata, 32'd8);

        for (int n = 0; n < 600; n++) begin
            logic [11:0] a;
            logic [31:0] wd;
            a  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 15)];
            wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            step($urandom_range(0, 7) != 0, 2'($urandom), a, wd,
                 $urandom_range(0, 3) == 0, 1'($urandom), "rand");
        end

        step(1'b1, 2'b01, 12'h7C0, 32'h1234, 1'b0, 1'b0, "pre_rst");
        csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h7C2; csr_wdata = 32'h5678;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rvalid", csr_rvalid, 1'b0);
        check("midrst_rdata", csr_rdata, 32'h0);
        model_clear();
        csr_valid = 1'b0; csr_op = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        rd(12'hB00, "post_rst_cyc");
        check("post_rst_cyc_val", csr_rdata, 32'h0);
        rd(12'hB82, "post_rst_insh");
        for (int i = 0; i < NS; i++) begin
            rd(SB + 12'(i), "post_rst_scr");
            check("post_rst_scr_val", csr_rdata, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode control/status register file for the RV32 core, replacing the flat 32-entry CSR array. Executes CSRRW/CSRRS/CSRRC read-modify-write accesses from the execute stage, provides a bank of custom scratch registers, and maintains 64-bit cycle and instret counters. Also flags illegal accesses. Results are registered and returned one cycle later for the writeback mux.

## Interface
- NUM_SCRATCH, 4: number of custom RW scratch CSRs, 1..16.
- SCRATCH_BASE, 12'h7C0: address of scratch register 0; scratch i lives at SCRATCH_BASE+i.
- CNT_W, 64: counter width, 33..64; high-half reads are zero-extended to 32 bits.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- csr_valid  in  1  access request this cycle
- csr_op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value or zero-extended uimm
- csr_src_zero  in  1  rs1==x0 / uimm==0; suppresses the write for RS/RC
- instr_retire  in  1  one instruction retired this cycle
- csr_rdata  out  32  old CSR value, registered
- csr_rvalid  out  1  csr_rdata/csr_illegal valid, one-cycle pulse
- csr_illegal  out  1  access rejected, registered

## Operation
- Implemented map:
  - mcycle/mcycleh: 0xB00/0xB80, RW.
  - minstret/minstreth: 0xB02/0xB82, RW.
  - cycle/cycleh: 0xC00/0xC80, RO alias.
  - instret/instreth: 0xC02/0xC82, RO alias.
  - scratch: SCRATCH_BASE..SCRATCH_BASE+NUM_SCRATCH-1, RW.
- Access condition: an access occurs when csr_valid=1 and csr_op≠00. csr_op=00 with csr_valid=1 is a no-op: no rvalid and no state change.
- New value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
- Write attempt: RW always attempts a write. RS/RC attempt a write only when csr_src_zero=0.
- Illegal when:
  - the address is unimplemented, or
  - a write is attempted to a RO address (addr[11:10]==2'b11).
- Illegal access behaviour: no state change, csr_rdata=0, csr_illegal=1.
- Legal RS/RC to a RO address with csr_src_zero=1 is a legal read.
- Counters:
  - mcycle increments by 1 every cycle out of reset.
  - minstret increments by 1 on each cycle with instr_retire=1.
  - Both wrap from 2^CNT_W-1 to 0.
  - Low-half write replaces bits [31:0] only; high-half write replaces bits [CNT_W-1:32] (excess wdata bits dropped).
  - Write to a counter in the same cycle as its increment: the written value wins and that cycle's increment is lost; the other half keeps its pre-edge value.
- Scratch registers are full 32-bit RW.

## Timing
- Reset (async): all outputs 0, counters 0, scratch 0.
- Access sampled at posedge N.
- Write commits at posedge N.
- csr_rdata/csr_illegal/csr_rvalid are valid during cycle N+1 (1-cycle latency). csr_rvalid is high for exactly one cycle unless another access is sampled at N+1.
- csr_rdata is the pre-edge value at posedge N: RS/RC return the old value, and mcycle reads the count before that edge's increment.
- Back-to-back accesses are supported every cycle; an access at N+1 observes the write from N.
- Reset mid-access: pending rvalid is dropped, all state is cleared.

## Test plan
- Reset, idle 10 cycles, read 0xB00 -> rdata=10 (count at the sampled edge), illegal=0, rvalid=1 for 1 cycle.
- RW 0x7C1 with 0xDEADBEEF, then RS 0x7C1 with 0x0000000F, then RC 0x7C1 with 0xFFFF0000 -> rdata sequence 0, 0xDEADBEEF, 0xDEADBEEF; final value 0x0000BEEF.
- RW 0xC00 -> illegal=1, rdata=0, mcycle keeps counting. RS 0xC00 with csr_src_zero=1 -> legal read. Access to 0x7C4 with NUM_SCRATCH=4 -> illegal.
- RW mcycle low=0xFFFFFFFF and high=0xFFFFFFFF on consecutive cycles; the wrap to 0 occurs shortly after and is checked by a read via 0xC00.
- Write minstret=5 in the same cycle as instr_retire=1 -> next read gives 5. Three further retires -> read gives 8.
- Assert rst while csr_rvalid is pending -> rvalid=0 and all CSRs read 0 after release.
